// File: rtl/fifo_sched_pkg.sv
// Types and defaults shared by the FIFO read-side scheduler and its skid buffer.
package fifo_sched_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int USEDW_W_DEF = 9;

    typedef enum logic {IDLE, BURST} state_e;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_W_DEF-1:0] data;
    } tword_t;

endpackage

// File: rtl/fifo_sched_skid.sv
// Two-entry skid buffer; entry 0 is the head and drives the stream outputs straight from flops.
module fifo_sched_skid
    import fifo_sched_pkg::*;
#(
    parameter type word_t = tword_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  word_t      push_word,
    input  logic       pop,
    output logic [1:0] occ,
    output word_t      head,
    output logic       valid
);

    word_t      e0_q, e0_d, e1_q, e1_d;
    logic [1:0] occ_q, occ_d;

    // pop is only ever asserted with valid, so occ_q >= 1 in the pop cases
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) e0_d = push_word;
                else               e1_d = push_word;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_word;
                end else begin
                    e0_d = push_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign occ   = occ_q;
    assign head  = e0_q;
    assign valid = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-side burst scheduler: waits for a full burst (or times out on a partial one),
// reads the FIFO back-to-back and emits a sop/eop framed valid/ready stream.
module fifo_rd_sched
    import fifo_sched_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int USEDW_W   = USEDW_W_DEF,
    parameter int BURST_LEN = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               enable,
    input  logic               rd_empty,
    input  logic [USEDW_W-1:0] rd_usedw,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               rd_req,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic               busy
);

    localparam int BL_W  = $clog2(BURST_LEN + 1);
    localparam int REM_W = (USEDW_W > BL_W) ? USEDW_W : BL_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } word_t;

    state_e           state_q, state_d;
    logic [REM_W-1:0] remain_q, remain_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             first_q, first_d;
    logic             pend_q, pend_sop_q, pend_eop_q;
    logic             req_sop, req_eop, space, pop, head_vld;
    logic [1:0]       skid_occ;
    word_t            head;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        tmo_d    = tmo_q;
        first_d  = first_q;
        rd_req   = 1'b0;
        req_sop  = 1'b0;
        req_eop  = 1'b0;
        // a request now lands in the skid two edges later; leave room for it
        space    = ({1'b0, skid_occ} + {2'b00, pend_q}) <= (3'd1 + {2'b00, pop});
        case (state_q)
            IDLE: begin
                if (!enable || rd_usedw == '0) begin
                    tmo_d = '0;
                end else if (int'(rd_usedw) >= BURST_LEN) begin
                    remain_d = REM_W'(BURST_LEN);
                    tmo_d    = '0;
                    first_d  = 1'b1;
                    state_d  = BURST;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    remain_d = REM_W'(rd_usedw);
                    tmo_d    = '0;
                    first_d  = 1'b1;
                    state_d  = BURST;
                end else if (tmo_q != {TMO_W{1'b1}}) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            BURST: begin
                rd_req = !rd_empty && (remain_q != '0) && space;
                if (rd_req) begin
                    req_sop  = first_q;
                    req_eop  = (remain_q == REM_W'(1));
                    first_d  = 1'b0;
                    remain_d = remain_q - REM_W'(1);
                    if (req_eop) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            remain_q   <= '0;
            tmo_q      <= '0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_sop_q <= 1'b0;
            pend_eop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            tmo_q      <= tmo_d;
            first_q    <= first_d;
            pend_q     <= rd_req;
            pend_sop_q <= req_sop;
            pend_eop_q <= req_eop;
        end
    end

    // FIFO is non-show-ahead: rd_data belongs to last cycle's request, tags travel alongside
    fifo_sched_skid #(.word_t(word_t)) u_skid (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (pend_q),
        .push_word ('{sop: pend_sop_q, eop: pend_eop_q, data: rd_data}),
        .pop       (pop),
        .occ       (skid_occ),
        .head      (head),
        .valid     (head_vld)
    );

    assign pop       = head_vld && out_ready;
    assign out_valid = head_vld;
    assign out_data  = head.data;
    assign out_sop   = head.sop;
    assign out_eop   = head.eop;
    assign busy      = (state_q == BURST) || pend_q || head_vld;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched with a behavioural non-show-ahead FIFO on the read side.
module tb_fifo_rd_sched;

    localparam int BIG = 1 << 30;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        rd_empty = 1'b1;
    logic [8:0]  rd_usedw = '0;
    logic [15:0] rd_data = '0;
    logic        rd_req;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sop;
    logic        out_eop;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    fifo_rd_sched #(.DATA_W(16), .USEDW_W(9), .BURST_LEN(64), .TIMEOUT(1024)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (enable),
        .rd_empty  (rd_empty),
        .rd_usedw  (rd_usedw),
        .rd_data   (rd_data),
        .rd_req    (rd_req),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .busy      (busy)
    );

    // FIFO storage: the stimulus owns wptr/mem, the model owns rptr; lim hides words to force empty
    logic [15:0] mem [0:1023];
    int          wptr = 0;
    int          rptr = 0;
    int          lim = BIG;
    bit          rnd_mode = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          und_err = 0;
    int          occ_err = 0;
    int          stab_err = 0;
    int          busy_cnt = 0;
    int          req_cyc[$];
    int          vld_cyc[$];
    logic [17:0] got[$];
    bit          prev_stall = 1'b0;
    logic [17:0] prev_w = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic int avail_top();
        return (wptr < lim) ? wptr : lim;
    endfunction

    // monitor at the edge, then FIFO/ready model updates 1 time unit later
    always @(posedge sys_clk) begin
        logic        req_s;
        logic [17:0] cur;
        cyc++;
        req_s = rd_req;
        cur   = {out_sop, out_eop, out_data};
        if (rd_req) req_cyc.push_back(cyc);
        if (out_valid) vld_cyc.push_back(cyc);
        if (out_valid && out_ready) got.push_back(cur);
        if (busy) busy_cnt++;
        if (dut.skid_occ > 2'd2) occ_err++;
        if (prev_stall && (!out_valid || cur != prev_w)) stab_err++;
        prev_stall = out_valid && !out_ready;
        prev_w     = cur;
        #1;
        if (req_s) begin
            if (rptr >= avail_top()) und_err++;
            else begin
                rd_data = mem[rptr % 1024];
                rptr++;
            end
        end
        rd_empty  = (rptr >= avail_top());
        rd_usedw  = rd_empty ? 9'd0 : 9'(avail_top() - rptr);
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr % 1024] = 16'(wptr);
            wptr++;
        end
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        chk({tag, "_complete"}, (got.size() >= n), 1);
    endtask

    task automatic verify_burst(input string tag, input int b, input int n, input int first);
        int seq_err = 0;
        int sops = 0;
        int eops = 0;
        for (int i = 0; i < n; i++) begin
            if (got[b+i][15:0] != 16'(first + i)) seq_err++;
            if (got[b+i][17]) sops++;
            if (got[b+i][16]) eops++;
        end
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_sop_first"}, got[b][17], 1);
        chk({tag, "_eop_last"}, got[b+n-1][16], 1);
        chk({tag, "_sop_cnt"}, sops, 1);
        chk({tag, "_eop_cnt"}, eops, 1);
    endtask

    initial begin
        int b, br, bv, bb, n, k, nxt, start;

        // reset hold, then idle with an empty FIFO
        enable = 1'b1;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sop_eop", {out_sop, out_eop}, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge sys_clk); #1 sys_rst_n = 1'b1;
        br = req_cyc.size(); bv = vld_cyc.size(); bb = busy_cnt;
        repeat (2000) @(posedge sys_clk);
        #2;
        chk("idle_rd_req_cnt", req_cyc.size() - br, 0);
        chk("idle_valid_cnt", vld_cyc.size() - bv, 0);
        chk("idle_busy_cnt", busy_cnt - bb, 0);

        // full burst, ready held high: 0x0000..0x003F
        @(negedge sys_clk);
        b = got.size(); br = req_cyc.size(); bv = vld_cyc.size();
        push_words(64);
        wait_words("full", b + 64, 500);
        repeat (5) @(negedge sys_clk);
        chk("full_req_cnt", req_cyc.size() - br, 64);
        chk("full_req_span", req_cyc[br+63] - req_cyc[br], 63);
        chk("full_latency", vld_cyc[bv] - req_cyc[br], 2);
        verify_burst("full", b, 64, 0);

        // partial burst after the idle timeout: 10 words 0x0040..0x0049
        b = got.size();
        push_words(10);
        @(posedge sys_clk); #2;
        n = 0;
        while (!rd_req && n < 3000) begin
            @(negedge sys_clk);
            if (!rd_req) n++;
        end
        chk("tmo_first_req_cycle", n, 1024);
        wait_words("tmo", b + 10, 200);
        verify_burst("tmo", b, 10, 64);

        // full burst under random backpressure
        @(negedge sys_clk);
        rnd_mode = 1'b1;
        b = got.size();
        push_words(64);
        wait_words("bp", b + 64, 2000);
        verify_burst("bp", b, 64, 74);
        rnd_mode = 1'b0;
        repeat (5) @(negedge sys_clk);

        // FIFO runs dry after 20 reads, refilled 50 cycles later
        b = got.size(); br = req_cyc.size();
        start = wptr;
        push_words(64);
        k = 0;
        while (req_cyc.size() == br && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        lim = start + 20;
        k = 0;
        while (rptr < lim && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        chk("drain_reached", rptr, start + 20);
        repeat (50) @(negedge sys_clk);
        lim = BIG;
        wait_words("drain", b + 64, 500);
        repeat (5) @(negedge sys_clk);
        chk("drain_req_cnt", req_cyc.size() - br, 64);
        chk("drain_gap_ge50", (req_cyc[br+20] - req_cyc[br+19]) >= 50, 1);
        verify_burst("drain", b, 64, start);

        // reset for one cycle at word 30, then a fresh burst
        b = got.size();
        push_words(64);
        k = 0;
        while (got.size() < b + 30 && k < 500) begin
            @(posedge sys_clk); #1;
            k++;
        end
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("mid_rst_rd_req", rd_req, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sop_eop", {out_sop, out_eop}, 0);
        nxt = rptr;
        b = got.size();
        push_words(64);
        wait_words("post_rst", b + 64, 500);
        verify_burst("post_rst", b, 64, nxt);

        chk("no_underflow", und_err, 0);
        chk("occ_le_2", occ_err, 0);
        chk("stall_stable", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
